// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC register feeding the icache, plus a circular buffer
// of {instruction, pc} entries that feeds up to two instructions per cycle to decode.
module fetch_queue #(
    parameter int          QUEUE_DEPTH = 16,
    parameter int          ISSUE_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    icache_pc,
    input  logic [3:0][31:0]               icache_inst,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    input  logic [1:0]                     deq_num,
    output logic [1:0]                     out_valid,
    output logic [1:0][31:0]               out_inst,
    output logic [1:0][31:0]               out_pc,
    output logic [$clog2(QUEUE_DEPTH):0]   count,
    output logic                           fetching
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc;
    logic [AW-1:0] head, tail;
    logic [31:0]   ent_inst [QUEUE_DEPTH];
    logic [31:0]   ent_pc   [QUEUE_DEPTH];
    logic [1:0]    req, k;

    assign icache_pc = pc;
    // Space check uses registered count so a full bundle always fits.
    assign fetching  = !rst && !redirect_valid && (count <= CW'(QUEUE_DEPTH - 4));
    assign req       = (deq_num > 2'(ISSUE_WIDTH)) ? 2'(ISSUE_WIDTH) : deq_num;
    assign k         = (CW'(req) > count) ? count[1:0] : req;

    assign out_valid   = {count >= CW'(2), count != '0};
    assign out_inst[0] = ent_inst[head];
    assign out_inst[1] = ent_inst[head + AW'(1)];
    assign out_pc[0]   = ent_pc[head];
    assign out_pc[1]   = ent_pc[head + AW'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fetching) begin
                tail <= tail + AW'(4);
                pc   <= pc + 32'd16;
            end
            head  <= head + AW'(k);
            count <= count + (fetching ? CW'(4) : CW'(0)) - CW'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (fetching) begin
            for (int i = 0; i < 4; i++) begin
                ent_inst[tail + AW'(i)] <= icache_inst[i];
                ent_pc[tail + AW'(i)]   <= pc + 32'(4 * i);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random stimulus checked against a queue-based model
// of the in-order instruction stream.
module tb_fetch_queue;
    localparam int D = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     icache_pc;
    logic [3:0][31:0] icache_inst;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [1:0]      deq_num;
    logic [1:0]      out_valid;
    logic [1:0][31:0] out_inst, out_pc;
    logic [4:0]      count;
    logic            fetching;

    int tests = 0;
    int fails = 0;
    logic [31:0] mq[$];
    logic [31:0] mpc;

    fetch_queue #(.QUEUE_DEPTH(D), .ISSUE_WIDTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .icache_pc(icache_pc), .icache_inst(icache_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_num(deq_num),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .count(count), .fetching(fetching)
    );

    always #5 clk = ~clk;

    // Memory contents differ from the address so pc/inst swaps are visible.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always_comb
        for (int i = 0; i < 4; i++) icache_inst[i] = mw(icache_pc + 32'(4 * i));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic [1:0] dn);
        int  k;
        logic f;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq_num        = dn;
        @(negedge clk);
        f = !rv && (mq.size() <= D - 4);
        chk("icache_pc", icache_pc, mpc);
        chk("count", 32'(count), 32'(mq.size()));
        chk("fetching", 32'(fetching), 32'(f));
        chk("out_valid", 32'(out_valid), 32'({mq.size() >= 2, mq.size() >= 1}));
        for (int i = 0; i < 2; i++)
            if (mq.size() > i) begin
                chk("out_pc", out_pc[i], mq[i]);
                chk("out_inst", out_inst[i], mw(mq[i]));
            end
        if (rv) begin
            mq.delete();
            mpc = rpc & ~32'h3;
        end else begin
            k = (dn == 2'd3) ? 2 : int'(dn);
            if (k > mq.size()) k = mq.size();
            repeat (k) void'(mq.pop_front());
            if (f) begin
                for (int i = 0; i < 4; i++) mq.push_back(mpc + 32'(4 * i));
                mpc += 32'd16;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        deq_num = '0;
        mpc = '0;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_fetching", 32'(fetching), 0);
        chk("rst_pc", icache_pc, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill from reset with no dequeue
        repeat (4) step(1'b0, '0, 2'd0);
        chk("s1_count", 32'(count), 16);
        chk("s1_pc", icache_pc, 32'h40);
        chk("s1_fetching", 32'(fetching), 0);
        chk("s1_out_pc0", out_pc[0], 32'h0);
        chk("s1_out_pc1", out_pc[1], 32'h4);

        // Drain two per cycle from full: 14, 12, then refetch to 14
        repeat (3) step(1'b0, '0, 2'd2);
        chk("s2_count", 32'(count), 14);
        chk("s2_head", out_pc[0], 32'h18);

        // Build count 10, then redirect to an unaligned pc
        step(1'b1, 32'h0, 2'd0);
        step(1'b0, '0, 2'd0);
        repeat (3) step(1'b0, '0, 2'd2);
        chk("s3_pre_count", 32'(count), 10);
        step(1'b1, 32'h103, 2'd2);
        chk("s3_count", 32'(count), 0);
        chk("s3_valid", 32'(out_valid), 0);
        chk("s3_pc", icache_pc, 32'h100);
        step(1'b0, '0, 2'd0);
        chk("s3_count2", 32'(count), 4);
        chk("s3_out_pc", out_pc[0], 32'h100);
        chk("s3_out_inst", out_inst[0], mw(32'h100));

        // Clamp: deq_num=3 on empty queue and on a full one
        step(1'b1, 32'h200, 2'd0);
        step(1'b0, '0, 2'd3);
        chk("s5_empty_clamp", 32'(count), 4);
        repeat (3) step(1'b0, '0, 2'd0);
        step(1'b0, '0, 2'd3);
        chk("s5_full_clamp", 32'(count), 14);

        // Continuous stream across several wraps
        step(1'b1, 32'h0, 2'd0);
        repeat (40) step(1'b0, '0, 2'd2);

        repeat (400)
            step($urandom_range(0, 19) == 0, $urandom, 2'($urandom));

        // Asynchronous reset between edges at count 9
        step(1'b1, 32'h0, 2'd0);
        step(1'b0, '0, 2'd0);
        step(1'b0, '0, 2'd2);
        step(1'b0, '0, 2'd1);
        chk("s6_pre_count", 32'(count), 9);
        #2 rst = 1'b1;
        #1;
        chk("s6_count", 32'(count), 0);
        chk("s6_valid", 32'(out_valid), 0);
        chk("s6_pc", icache_pc, 32'h0);
        chk("s6_fetching", 32'(fetching), 0);
        mq.delete();
        mpc = 32'h0;
        deq_num = 2'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) step(1'b0, '0, 2'd0);
        chk("s6_refill_count", 32'(count), 16);
        chk("s6_refill_pc", icache_pc, 32'h40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch-side requester for the instruction cache.
- Holds the fetch PC and drives it to the icache every cycle.
- Captures the 4-wide instruction bundle the icache returns combinationally and buffers each instruction with its PC in a circular queue.
- Presents up to 2 in-order instructions per cycle to decode; a branch/exception redirect flushes the queue and restarts fetch.

Parameters:
- QUEUE_DEPTH, 16, number of instruction entries; power of two, >= 8.
- ISSUE_WIDTH, 2, max instructions dequeued per cycle; fixed at 2 in this revision.
- RESET_PC, 32'h00000000, fetch PC after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- icache_pc  output  32  fetch PC to the icache; word aligned.
- icache_inst  input  4x32  instructions at icache_pc, +4, +8, +12; valid in the same cycle.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0.
- deq_num  input  2  instructions decode consumes this cycle (0..2; 3 treated as 2).
- out_valid  output  2  out_valid[i] = slot i holds a valid instruction.
- out_inst  output  2x32  instructions at head and head+1.
- out_pc  output  2x32  PCs of out_inst.
- count  output  clog2(QUEUE_DEPTH)+1  current occupancy.
- fetching  output  1  a bundle is enqueued at the coming clock edge.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC; head = tail = 0; count = 0.
  - out_valid = 0; fetching = 0 while rst is asserted.
  - Queue storage contents are don't-care.
- icache_pc = pc register; no added latency. A bundle is consumed in the same cycle icache_pc is presented.
- Fetch condition: fetching = !redirect_valid && (QUEUE_DEPTH - count >= 4).
  - Uses registered count, not post-dequeue count, so overflow is impossible.
- On fetch, at the clock edge:
  - Entry (tail+i) mod QUEUE_DEPTH is written with {icache_inst[i], pc + 4*i} for i = 0..3.
  - tail += 4 (mod QUEUE_DEPTH); pc += 16 (32-bit wrap).
  - The whole bundle is always enqueued; no partial bundles, including when pc is not 16-byte aligned.
- Dequeue:
  - k = min(min(deq_num, 2), count).
  - head += k (mod QUEUE_DEPTH).
  - Requests beyond the valid entries are silently clamped, never an error.
- Occupancy: count_next = count + 4*fetching - k; count never exceeds QUEUE_DEPTH.
- Outputs, combinational from head:
  - out_valid[0] = (count >= 1); out_valid[1] = (count >= 2).
  - out_inst/out_pc from entries head and (head+1) mod QUEUE_DEPTH.
  - When out_valid[i] = 0, out_inst[i] and out_pc[i] are don't-care.
- Redirect has priority over fetch and dequeue:
  - Next edge: head = tail = 0, count = 0, pc = {redirect_pc[31:2], 2'b00}.
  - deq_num is ignored that cycle.
  - The following cycle fetches from the new pc when space allows (queue is empty).
- Wrap-around: head and tail wrap modulo QUEUE_DEPTH. Full is count == QUEUE_DEPTH; empty is count == 0; the two are never ambiguous.
- Simultaneous fetch and dequeue in one cycle are both applied.

Test Plan:
1. Reset, then release with deq_num=0, icache model returning word = address:
   - count goes 4, 8, 12, 16 on successive edges; fetching = 0 at count 16.
   - icache_pc = 0x40; out_pc[0] = 0x0, out_pc[1] = 0x4.
2. From full (count=16), hold deq_num=2:
   - count goes 14, then 12.
   - Next cycle fetches: count 14 (12 - 2 + 4).
   - out_pc stream sequential 0x0, 0x4, 0x8, ... with no gaps or duplicates.
3. Redirect with count=10, redirect_pc=0x103:
   - Next cycle count = 0, out_valid = 0, icache_pc = 0x100.
   - The cycle after: count = 4, out_pc[0] = 0x100, out_inst[0] = mem[0x100].
4. Wrap check, continuous fetch with deq_num=2:
   - The entry at the 17th fetch position (slot 0 reused) carries pc 0x40.
   - Dequeued PCs remain strictly +4 across the wrap.
5. Clamp cases:
   - count=1, deq_num=2: next count = 0 (or 4 if fetching); out_valid[1] was 0.
   - deq_num=3: treated as 2.
6. Assert rst mid-stream at count=9, asynchronously between edges:
   - Outputs clear immediately (out_valid = 0, count = 0, icache_pc = RESET_PC).
   - After release, refill proceeds as in scenario 1.
